// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the serial debug port UART blocks.
//   - FSM state encoding used by fifo_uart_tx (3-bit, legacy-compatible values)
//   - Frame shape constants for 8N1 framing
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and asserts tick while the
// count sits at its last value. The count wraps after a tick and is forced
// back to zero by clear, so the owner can realign it on every state entry.
// Ports:
//   CLK    in   system clock
//   RSTn   in   asynchronous active-low reset
//   clear  in   restart the bit period on the next edge
//   tick   out  high in the last cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule : uart_baud_tick

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Pops bytes from the 16x8 synchronous FIFO and serializes them as UART 8N1
// (start bit, 8 data bits LSB first, stop bit). Frames run back to back while
// enable is high and the FIFO has data.
// Ports:
//   CLK         in   system clock
//   RSTn        in   asynchronous active-low reset (abandons any frame)
//   enable      in   permits starting a new frame
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO registered read data (valid the cycle after a pop)
//   fifo_read   out  one-cycle pop strobe
//   txd         out  serial line, idle high
//   busy        out  high whenever not idle
//   frame_done  out  pulse in the last cycle of the stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read,
    output logic       txd,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [2:0] state;
    logic [2:0] state_next;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       tick;
    logic       clear;

    logic can_start;
    assign can_start = enable && !fifo_empty;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (can_start) state_next = ST_FETCH;
            ST_FETCH: state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_START;
            ST_START: if (tick) state_next = ST_DATA;
            ST_DATA:  if (tick && (bit_cnt == LAST_BIT)) state_next = ST_STOP;
            ST_STOP:  if (tick) state_next = can_start ? ST_FETCH : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Any state change realigns the bit period so each state starts at count 0.
    assign clear = (state_next != state);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .clear (clear),
        .tick  (tick)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    shreg   <= fifo_data;
                    bit_cnt <= '0;
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from registered state only; async reset to IDLE forces
    // the line high immediately.
    always_comb begin
        txd = 1'b1;
        case (state)
            ST_START: txd = 1'b0;
            ST_DATA:  txd = shreg[0];
            default:  txd = 1'b1;
        endcase
    end

    assign fifo_read  = (state == ST_FETCH);
    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_STOP) && tick;

endmodule : fifo_uart_tx

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Directed testbench for fifo_uart_tx with CLKS_PER_BIT=4 and a small
// behavioural model of the 16x8 FIFO (combinational empty, registered data).
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 2 + 10 * CPB;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read;
    logic       txd;
    logic       busy;
    logic       frame_done;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_read  (fifo_read),
        .txd        (txd),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // FIFO model
    logic [7:0] mem [0:15];
    logic [4:0] wr_ptr = 5'd0;
    logic [4:0] rd_ptr = 5'd0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge CLK) begin
        if (fifo_read) begin
            fifo_data <= mem[rd_ptr[3:0]];
            rd_ptr    <= rd_ptr + 5'd1;
        end
    end

    // A pop must only follow a cycle in which the FIFO was non-empty.
    logic empty_prev = 1'b1;
    always @(posedge CLK) begin
        if (fifo_read) begin
            n_cmp++;
            if (empty_prev) begin
                n_fail++;
                $display("FAIL pop_guard: fifo_read=1 but fifo_empty was 1 the cycle before");
            end
        end
        empty_prev <= fifo_empty;
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    // Expected line level for bit-timed cycle k (0 = first start-bit cycle).
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        int slot;
        slot = k / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    // Advance negedges until fifo_read is seen; leaves time at that negedge.
    task automatic wait_fetch(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (fifo_read) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        repeat (2) @(negedge CLK);
        n_cmp++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (fifo_read !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b want 0", fifo_read); end
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", frame_done); end
        RSTn = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single_frame();
        bit ok;
        int reads;
        int dones;
        logic e;
        push(8'hA5);
        enable = 1'b1;
        wait_fetch(5, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_fetch: no fifo_read within 5 cycles"); end
        reads = 1;
        dones = 0;
        for (int idx = 1; idx < FRAME; idx++) begin
            @(negedge CLK);
            e = (idx < 2) ? 1'b1 : exp_bit(8'hA5, idx - 2);
            n_cmp++; if (txd !== e) begin n_fail++; $display("FAIL single_txd[%0d]: got %b want %b", idx, txd, e); end
            if (fifo_read) reads++;
            if (frame_done) dones++;
            if (idx == FRAME - 1) begin
                n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL single_done_pos: got %b want 1 at cycle 42", frame_done); end
            end
        end
        repeat (5) begin
            @(negedge CLK);
            if (fifo_read) reads++;
            if (frame_done) dones++;
        end
        n_cmp++; if (reads !== 1) begin n_fail++; $display("FAIL single_reads: got %0d want 1", reads); end
        n_cmp++; if (dones !== 1) begin n_fail++; $display("FAIL single_dones: got %0d want 1", dones); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
        enable = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int reads;
        int run;
        int f;
        int k;
        logic e;
        logic er;
        logic hist [0:2*FRAME+2];
        push(8'h00);
        push(8'hFF);
        enable = 1'b1;
        wait_fetch(5, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b_fetch: no fifo_read within 5 cycles"); end
        reads = 1;
        hist[0] = txd;
        for (int idx = 1; idx <= 2*FRAME + 2; idx++) begin
            @(negedge CLK);
            hist[idx] = txd;
            f = idx / FRAME;
            k = idx % FRAME;
            if (idx >= 2*FRAME) e = 1'b1;
            else if (k < 2) e = 1'b1;
            else e = exp_bit((f == 0) ? 8'h00 : 8'hFF, k - 2);
            er = (idx == FRAME);
            n_cmp++; if (txd !== e) begin n_fail++; $display("FAIL b2b_txd[%0d]: got %b want %b", idx, txd, e); end
            n_cmp++; if (fifo_read !== er) begin n_fail++; $display("FAIL b2b_read[%0d]: got %b want %b", idx, fifo_read, er); end
            if (fifo_read) reads++;
        end
        run = 0;
        for (int i = 2 + 9*CPB; i <= 2*FRAME + 2; i++) begin
            if (hist[i] !== 1'b1) break;
            run++;
        end
        n_cmp++; if (run !== CPB + 2) begin n_fail++; $display("FAIL b2b_gap: high run %0d want %0d", run, CPB + 2); end
        repeat (20) begin
            @(negedge CLK);
            if (fifo_read) reads++;
        end
        n_cmp++; if (reads !== 2) begin n_fail++; $display("FAIL b2b_reads: got %0d want 2", reads); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
        enable = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_enable_gate();
        int bad;
        push(8'h5A);
        enable = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge CLK);
            if (fifo_read !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || txd !== 1'b1) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL gate_hold: %0d cycles active, want 0", bad); end
        enable = 1'b1;
        @(negedge CLK);
        n_cmp++; if (fifo_read !== 1'b1) begin n_fail++; $display("FAIL gate_fetch_next_edge: fifo_read got %b want 1", fifo_read); end
        enable = 1'b0;
        bad = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (!busy) begin bad = 0; break; end
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL gate_frame_end: busy still 1 after 60 cycles"); end
        @(negedge CLK);
    endtask

    task automatic test_enable_drop();
        bit ok;
        int reads;
        int left;
        logic e;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        enable = 1'b1;
        wait_fetch(5, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL drop_fetch: no fifo_read within 5 cycles"); end
        for (int idx = 1; idx < FRAME; idx++) begin
            @(negedge CLK);
            if (idx == 20) enable = 1'b0;
            e = (idx < 2) ? 1'b1 : exp_bit(8'h11, idx - 2);
            n_cmp++; if (txd !== e) begin n_fail++; $display("FAIL drop_txd[%0d]: got %b want %b", idx, txd, e); end
        end
        n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL drop_done: got %b want 1", frame_done); end
        reads = 0;
        repeat (60) begin
            @(negedge CLK);
            if (fifo_read) reads++;
        end
        left = int'(wr_ptr - rd_ptr);
        n_cmp++; if (reads !== 0) begin n_fail++; $display("FAIL drop_reads: got %0d want 0", reads); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %b want 0", busy); end
        n_cmp++; if (left !== 2) begin n_fail++; $display("FAIL drop_left: got %0d bytes want 2", left); end
        // Drain the two remaining bytes so later tests start from an empty FIFO.
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (fifo_empty && !busy) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL drop_drain: FIFO not drained within 300 cycles"); end
        enable = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_async_reset();
        bit ok;
        logic e;
        push(8'h34);
        push(8'h96);
        enable = 1'b1;
        wait_fetch(5, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL areset_fetch: no fifo_read within 5 cycles"); end
        repeat (19) @(negedge CLK);
        n_cmp++; if (txd !== 1'b0) begin n_fail++; $display("FAIL areset_bit3: got %b want 0", txd); end
        #2;
        RSTn = 1'b0;
        #1;
        n_cmp++; if (txd !== 1'b1) begin n_fail++; $display("FAIL areset_txd: got %b want 1", txd); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b want 0", busy); end
        @(negedge CLK);
        RSTn = 1'b1;
        wait_fetch(5, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL areset_refetch: no fifo_read within 5 cycles"); end
        for (int idx = 1; idx < FRAME; idx++) begin
            @(negedge CLK);
            e = (idx < 2) ? 1'b1 : exp_bit(8'h96, idx - 2);
            n_cmp++; if (txd !== e) begin n_fail++; $display("FAIL areset_txd[%0d]: got %b want %b", idx, txd, e); end
        end
        n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL areset_done: got %b want 1", frame_done); end
        enable = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_empty_idle();
        int reads;
        int busy_cnt;
        enable = 1'b1;
        reads = 0;
        busy_cnt = 0;
        repeat (200) begin
            @(negedge CLK);
            if (fifo_read) reads++;
            if (busy || !txd) busy_cnt++;
        end
        n_cmp++; if (reads !== 0) begin n_fail++; $display("FAIL empty_reads: got %0d want 0", reads); end
        n_cmp++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL empty_activity: %0d active cycles want 0", busy_cnt); end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_enable_gate();
        test_enable_drop();
        test_async_reset();
        test_empty_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_fifo_uart_tx
